// File: rtl/hsi_tx_arbiter.sv
// hsi_tx_arbiter: two-source message arbiter feeding a byte coder.
// Round-robin grant on ties, one byte per coder busy/idle handshake,
// with watchdog, length-overflow and receive-side abort paths.
module hsi_tx_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [1:0] d_rdy,
  input  logic [1:0] d_last,
  output logic [1:0] d_ack,
  output logic [1:0] gnt,
  input  logic       cd_busy,
  input  logic       rx_err,
  output logic [7:0] q,
  output logic       q_rdy,
  output logic       msg_end,
  output logic       abort,
  output logic       busy
);

  // Watchdog must be able to reach TIMEOUT; never narrower than 8 bits.
  localparam int WD_W = (TIMEOUT >= 256) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            ptr_q, ptr_d;
  logic [7:0]      q_q, q_d;
  logic            q_rdy_q, q_rdy_d;
  logic [1:0]      d_ack_q, d_ack_d;
  logic            msg_end_q, msg_end_d;
  logic            abort_q, abort_d;
  logic            last_q, last_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic            gidx;
  logic            gsel;
  logic [7:0]      dsel;
  logic            kill;

  // Index of the granted requester and its presented byte.
  assign gidx = gnt_q[1];
  assign dsel = gidx ? d1 : d0;

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    q_d       = q_q;
    q_rdy_d   = 1'b0;
    d_ack_d   = 2'b00;
    msg_end_d = 1'b0;
    abort_d   = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gsel      = 1'b0;
    // Receive-side error or expired watchdog outrank everything else.
    kill      = (state_q != IDLE) && (rx_err || (wd_q == WD_W'(TIMEOUT)));

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie the pointer names the last winner; pick the other one.
          gsel    = (req == 2'b11) ? ~ptr_q : req[1];
          gnt_d   = gsel ? 2'b10 : 2'b01;
          ptr_d   = gsel;
          cnt_d   = 7'd0;
          last_d  = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (d_rdy[gidx] && !cd_busy) begin
          q_d           = dsel;
          q_rdy_d       = 1'b1;
          d_ack_d[gidx] = 1'b1;
          last_d        = d_last[gidx];
          cnt_d         = cnt_q + 7'd1;
          state_d       = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (cd_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!cd_busy) begin
          if (last_q) begin
            msg_end_d = 1'b1;
            gnt_d     = 2'b00;
            state_d   = IDLE;
          end else if (cnt_q >= 7'(MAX_LEN)) begin
            // Message hit its length limit without a last marker.
            abort_d = 1'b1;
            gnt_d   = 2'b00;
            state_d = IDLE;
          end else begin
            state_d = XFER;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (kill) begin
      q_d       = q_q;
      q_rdy_d   = 1'b0;
      d_ack_d   = 2'b00;
      msg_end_d = 1'b0;
      last_d    = last_q;
      cnt_d     = cnt_q;
      abort_d   = 1'b1;
      gnt_d     = 2'b00;
      state_d   = IDLE;
    end

    // Watchdog restarts on every state change and runs while not idle.
    if (state_d != state_q)   wd_d = '0;
    else if (state_q != IDLE) wd_d = wd_q + 1'b1;
    else                      wd_d = '0;
  end

  // State and output registers; reset discards any message in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      ptr_q     <= 1'b1;
      q_q       <= 8'h00;
      q_rdy_q   <= 1'b0;
      d_ack_q   <= 2'b00;
      msg_end_q <= 1'b0;
      abort_q   <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= 7'd0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      q_q       <= q_d;
      q_rdy_q   <= q_rdy_d;
      d_ack_q   <= d_ack_d;
      msg_end_q <= msg_end_d;
      abort_q   <= abort_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_rdy   = q_rdy_q;
  assign d_ack   = d_ack_q;
  assign msg_end = msg_end_q;
  assign abort   = abort_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/hsi_tx_arbiter.md
HSI_TX_ARBITER -- requirements
Module: hsi_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for a requester byte or a coder handshake before aborting.
REQ-002 Parameter MAX_LEN, default 64: maximum bytes per message, including the last byte.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-requester message request, level; bit0 = status source, bit1 = data source.
REQ-006 d0, d1  in  8 each  byte presented by requester 0 / 1.
REQ-007 d_rdy  in  2  per-requester byte valid, held until acked.
REQ-008 d_last  in  2  per-requester marker: the presented byte is the final byte of the message.
REQ-009 d_ack  out  2  one-cycle pulse; the presented byte was consumed.
REQ-010 gnt  out  2  one-hot grant, or zero when idle.
REQ-011 cd_busy  in  1  coder busy flag.
REQ-012 rx_err  in  1  abort request from the receive side.
REQ-013 q  out  8  byte to the coder.
REQ-014 q_rdy  out  1  one-cycle strobe; q is valid.
REQ-015 msg_end  out  1  one-cycle pulse; the message completed normally.
REQ-016 abort  out  1  one-cycle pulse; the message was terminated early.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, XFER, WAIT_HI, WAIT_LO.
REQ-019 IDLE arbitration, when req is nonzero:
- Exactly one bit set: grant that requester.
- Both bits set: grant the requester not granted last (round-robin pointer).
- Grant is registered and visible the cycle after the decision; next state is XFER.
REQ-020 Pointer value after reset selects requester 0 on the first tie.
REQ-021 Pointer update: set to the granted index on grant.
REQ-022 gnt holds until message end or abort; deasserting req mid-message is ignored.
REQ-023 XFER acceptance, when d_rdy[g] = 1 and cd_busy = 0, in the same edge:
- q <= d_g; q_rdy = 1 for one cycle; d_ack[g] = 1 for one cycle.
- Latch d_last[g] and increment the byte count.
- Next state: WAIT_HI.
REQ-024 In XFER, d_rdy with cd_busy = 1 is not consumed.
REQ-025 WAIT_HI: on cd_busy = 1, go to WAIT_LO.
REQ-026 WAIT_LO, on cd_busy = 0:
- Latched last = 1: pulse msg_end, clear gnt, go to IDLE.
- Otherwise: return to XFER.
REQ-027 Watchdog: an 8-bit-or-wider counter clears on every state change and increments each cycle in XFER, WAIT_HI and WAIT_LO.
REQ-028 Watchdog expiry: counter == TIMEOUT causes an abort.
REQ-029 Byte count: 7-bit, cleared at grant.
REQ-030 Length overflow: accepting byte number MAX_LEN with d_last = 0 causes an abort after that byte's WAIT_LO completes.
REQ-031 Abort sequence: pulse abort for one cycle, clear gnt, go to IDLE, with no msg_end.
REQ-032 rx_err = 1 in any non-IDLE state aborts on that edge; abort has priority over msg_end, d_ack and q_rdy.
REQ-033 rx_err in IDLE is ignored.
REQ-034 Arbitration may regrant on the cycle after return to IDLE; there is no back-to-back grant in the same cycle as msg_end or abort.
REQ-035 The single-byte message (d_last on the first byte) is legal.
REQ-036 q holds its last value between strobes.

Reset
REQ-037 While rst = 1, asynchronously force:
- FSM = IDLE; gnt = 0; q = 0x00.
- q_rdy, d_ack, msg_end, abort, busy = 0.
- Pointer = 1, byte count = 0, watchdog = 0.
REQ-038 Reset asserted mid-message discards the message without an abort pulse.
REQ-039 Release is synchronous-safe: the first arbitration happens no earlier than the first edge after rst falls.

Verification
REQ-040 Request 0 only; message bytes 0xA5, 0x3C (last), coder busy 4 cycles per byte:
- Two q_rdy pulses, q = 0xA5 then 0x3C.
- One msg_end, gnt 01 then 00.
REQ-041 req = 11 simultaneously after reset:
- gnt 01 first, then 10 for the next message.
- Repeat; the order alternates.
REQ-042 Granted requester never asserts d_rdy: abort pulse exactly TIMEOUT+1 cycles after XFER entry; gnt cleared; no q_rdy.
REQ-043 rx_err asserted during WAIT_LO of byte 2: abort next edge, no msg_end, busy falls.
REQ-044 MAX_LEN = 4 and a requester sends 5 bytes without d_last: 4 q_rdy pulses, then abort.
REQ-045 rst pulsed mid-XFER: all outputs 0 immediately; the next tie grants requester 0.
